// File: rtl/blackbox_delta_pkg.sv
// Shared definitions for the blackbox delta decoder slice.
// Latency: none (types and constants only).
// Backpressure: not applicable.
// Contents: decState_t (IDLE/RUN/STALL) and defaultDepth, the default output buffer depth.
package blackbox_delta_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no sample since reset or clear; history is zero
        RUN   = 2'd1,   // history valid, buffer has room
        STALL = 2'd2    // buffer full, input held off
    } decState_t;

    localparam int defaultDepth = 4;

endpackage

// File: rtl/blackbox_delta_fifo.sv
// Generic show-ahead FIFO whose head word and valid flag sit in flops.
// Latency: a word pushed into an empty FIFO appears on io_rdData the next cycle.
// Backpressure: io_full blocks pushes; a push while full is dropped, and a pop on the same cycle does not make room for it.
// Ports: io_clockPin/io_resetPin (async active-high), io_push/io_wrData write side,
//        io_pop/io_rdValid/io_rdData read side, io_full current status, io_fullNext status after this edge.
module blackbox_delta_fifo #(
    parameter int width = 12,
    parameter int depth = 4
) (
    input  logic             io_clockPin,
    input  logic             io_resetPin,
    input  logic             io_push,
    input  logic [width-1:0] io_wrData,
    input  logic             io_pop,
    output logic             io_full,
    output logic             io_fullNext,
    output logic             io_rdValid,
    output logic [width-1:0] io_rdData
);

    localparam int ptrW = $clog2(depth);
    localparam int cntW = $clog2(depth + 1);

    if (depth < 2 || (depth & (depth - 1)) != 0) begin : gBadDepth
        $error("blackbox_delta_fifo: depth must be a power of two >= 2");
    end

    logic [width-1:0] mem [depth];
    logic [ptrW-1:0]  wrPtr;
    logic [ptrW-1:0]  rdPtr;
    logic [ptrW-1:0]  rdPtrPlus1;
    logic [cntW-1:0]  count;
    logic [cntW-1:0]  countNext;
    logic             doPush;
    logic             doPop;

    assign io_full     = (count == cntW'(depth));
    assign doPush      = io_push && !io_full;
    assign doPop       = io_pop && (count != '0);
    assign rdPtrPlus1  = rdPtr + 1'b1;
    assign io_fullNext = (countNext == cntW'(depth));

    always_comb begin
        countNext = count;
        if (doPush && !doPop) begin
            countNext = count + 1'b1;
        end else if (doPop && !doPush) begin
            countNext = count - 1'b1;
        end
    end

    // Storage needs no reset: only entries between rdPtr and wrPtr are ever read.
    always_ff @(posedge io_clockPin) begin
        if (doPush) begin
            mem[wrPtr] <= io_wrData;
        end
    end

    always_ff @(posedge io_clockPin or posedge io_resetPin) begin
        if (io_resetPin) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            io_rdValid <= 1'b0;
            io_rdData  <= '0;
        end else begin
            count      <= countNext;
            io_rdValid <= (countNext != '0);
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtrPlus1;
            end
            // Head register: refill from the next stored entry, or take the
            // incoming word directly when it becomes the only entry.
            if (doPop) begin
                if (count > cntW'(1)) begin
                    io_rdData <= mem[rdPtrPlus1];
                end else if (doPush) begin
                    io_rdData <= io_wrData;
                end
            end else if (count == '0 && doPush) begin
                io_rdData <= io_wrData;
            end
        end
    end

endmodule

// File: rtl/blackbox_delta_decoder.sv
// Recovers per-sample increments from two running-sum lanes and buffers the delta pairs.
// Latency: a pair accepted at cycle N is on io_deltaA/B at cycle N+1 when the buffer was empty.
// Backpressure: io_inReady drops while the buffer is full; outputs hold while io_outValid && !io_outReady.
// Ports: io_clockPin, io_resetPin (async active-high), io_clear (sync re-base of history),
//        io_inValid/io_inReady/io_sumA/io_sumB input handshake, io_outValid/io_outReady/io_deltaA/io_deltaB
//        output handshake, io_state decoder state; io_errCount only when BLACKBOX_DELTA_CHECK_EN is defined.
module blackbox_delta_decoder
    import blackbox_delta_pkg::*;
#(
    parameter int aWidth    = 8,
    parameter int bWidth    = 4,
    parameter int depth     = defaultDepth,
    parameter int aMaxDelta = 2**aWidth - 1,
    parameter int bMaxDelta = 2**bWidth - 1
) (
    input  logic              io_clockPin,
    input  logic              io_resetPin,
    input  logic              io_clear,
    input  logic              io_inValid,
    output logic              io_inReady,
    input  logic [aWidth-1:0] io_sumA,
    input  logic [bWidth-1:0] io_sumB,
    output logic              io_outValid,
    input  logic              io_outReady,
    output logic [aWidth-1:0] io_deltaA,
    output logic [bWidth-1:0] io_deltaB,
`ifdef BLACKBOX_DELTA_CHECK_EN
    output logic [7:0]        io_errCount,
`endif
    output logic [1:0]        io_state
);

    if (aMaxDelta < 0 || aMaxDelta > 2**aWidth - 1 ||
        bMaxDelta < 0 || bMaxDelta > 2**bWidth - 1) begin : gBadMaxDelta
        $error("blackbox_delta_decoder: max delta outside lane range");
    end

    typedef struct packed {
        logic [aWidth-1:0] a;
        logic [bWidth-1:0] b;
    } deltaPair_t;

    decState_t   stateQ;
    decState_t   stateD;
    deltaPair_t  wrPair;
    deltaPair_t  rdPair;
    logic [aWidth-1:0] prevA;
    logic [bWidth-1:0] prevB;
    logic [aWidth-1:0] baseA;
    logic [bWidth-1:0] baseB;
    logic        fifoFull;
    logic        fifoFullNext;
    logic        accept;
    logic        pop;

    assign io_inReady = !fifoFull;
    assign accept     = io_inValid && !fifoFull;
    assign pop        = io_outValid && io_outReady;

    // A clear on the same cycle as a sample re-bases that sample against zero.
    assign baseA    = io_clear ? '0 : prevA;
    assign baseB    = io_clear ? '0 : prevB;
    assign wrPair.a = io_sumA - baseA;
    assign wrPair.b = io_sumB - baseB;

    always_ff @(posedge io_clockPin or posedge io_resetPin) begin
        if (io_resetPin) begin
            prevA <= '0;
            prevB <= '0;
        end else if (accept) begin
            prevA <= io_sumA;
            prevB <= io_sumB;
        end else if (io_clear) begin
            prevA <= '0;
            prevB <= '0;
        end
    end

    blackbox_delta_fifo #(
        .width(aWidth + bWidth),
        .depth(depth)
    ) uFifo (
        .io_clockPin(io_clockPin),
        .io_resetPin(io_resetPin),
        .io_push    (accept),
        .io_wrData  (wrPair),
        .io_pop     (pop),
        .io_full    (fifoFull),
        .io_fullNext(fifoFullNext),
        .io_rdValid (io_outValid),
        .io_rdData  (rdPair)
    );

    assign io_deltaA = rdPair.a;
    assign io_deltaB = rdPair.b;

    always_ff @(posedge io_clockPin or posedge io_resetPin) begin
        if (io_resetPin) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // IDLE persists (even across pops) until a sample is accepted; once
    // history is valid the state simply tracks whether the buffer is full.
    always_comb begin
        stateD = stateQ;
        if (io_clear && !accept) begin
            stateD = IDLE;
        end else if (accept || stateQ != IDLE) begin
            stateD = fifoFullNext ? STALL : RUN;
        end
    end

    always_comb begin
        io_state = stateQ;
    end

`ifdef BLACKBOX_DELTA_CHECK_EN
    localparam logic [aWidth:0] aMaxLim = (aWidth + 1)'(aMaxDelta);
    localparam logic [bWidth:0] bMaxLim = (bWidth + 1)'(bMaxDelta);

    logic overLimit;
    assign overLimit = ({1'b0, wrPair.a} > aMaxLim) || ({1'b0, wrPair.b} > bMaxLim);

    always_ff @(posedge io_clockPin or posedge io_resetPin) begin
        if (io_resetPin) begin
            io_errCount <= '0;
        end else if (accept && overLimit && io_errCount != 8'hFF) begin
            io_errCount <= io_errCount + 1'b1;
        end
    end
`endif

endmodule
